// File: rtl/cache_data_array_nway.sv
// N-way cache data array: byte-enabled processor word access plus critical-word-first
// line refill from memory over a valid/ready beat handshake.
module cache_data_array_nway #(
  parameter int unsigned INDEX_BITS  = 4,
  parameter int unsigned OFFSET_BITS = 2,
  parameter int unsigned WAY_BITS    = 2,
  parameter int unsigned WORD_W      = 32,
  localparam int unsigned BE_W       = WORD_W / 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [INDEX_BITS-1:0]  index,
  input  logic [OFFSET_BITS-1:0] offset,
  input  logic [WAY_BITS-1:0]    way,
  input  logic [BE_W-1:0]        byte_en,
  input  logic [WORD_W-1:0]      write_data,
  output logic                   proc_ready,
  output logic [WORD_W-1:0]      read_data,
  output logic                   read_valid,
  input  logic                   refill_start,
  input  logic [INDEX_BITS-1:0]  refill_index,
  input  logic [WAY_BITS-1:0]    refill_way,
  input  logic [OFFSET_BITS-1:0] refill_offset,
  input  logic                   mem_valid,
  input  logic [WORD_W-1:0]      mem_data,
  output logic                   mem_ready,
  output logic                   refill_busy,
  output logic                   refill_done,
  output logic                   crit_valid,
  output logic [WORD_W-1:0]      crit_data
);
  localparam int unsigned ADDR_W = WAY_BITS + INDEX_BITS + OFFSET_BITS;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef enum logic {StIdle, StRefill} state_e;

  state_e                 state_q, state_d;
  logic [INDEX_BITS-1:0]  ref_index_q;
  logic [WAY_BITS-1:0]    ref_way_q;
  logic [OFFSET_BITS-1:0] ref_offset_q;
  logic [OFFSET_BITS-1:0] beat_q;
  logic [WORD_W-1:0]      read_data_q;
  logic                   read_valid_q;
  logic                   refill_done_q;
  logic                   crit_valid_q;
  logic [WORD_W-1:0]      crit_data_q;

  logic [WORD_W-1:0] mem [DEPTH];

  logic              busy;
  logic              beat_fire;
  logic              last_beat;
  logic              line_conflict;
  logic              proc_wr;
  logic              proc_rd;
  logic [ADDR_W-1:0] proc_addr;
  logic [ADDR_W-1:0] refill_addr;

  assign busy          = (state_q == StRefill);
  assign beat_fire     = busy && mem_valid;
  assign last_beat     = beat_fire && (beat_q == '1);
  // Only the line under refill is blocked; every other line is a distinct address.
  assign line_conflict = busy && ({index, way} == {ref_index_q, ref_way_q}) && (rd_en || wr_en);
  assign proc_ready    = !line_conflict;
  assign proc_wr       = wr_en && proc_ready;
  assign proc_rd       = rd_en && proc_ready;
  assign proc_addr     = {way, index, offset};
  assign refill_addr   = {ref_way_q, ref_index_q, OFFSET_BITS'(ref_offset_q + beat_q)};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (refill_start) state_d = StRefill;
      StRefill: if (last_beat) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (proc_wr) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (byte_en[i]) mem[proc_addr][8*i +: 8] <= write_data[8*i +: 8];
      end
    end
    if (beat_fire) mem[refill_addr] <= mem_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      ref_index_q   <= '0;
      ref_way_q     <= '0;
      ref_offset_q  <= '0;
      beat_q        <= '0;
      read_data_q   <= '0;
      read_valid_q  <= 1'b0;
      refill_done_q <= 1'b0;
      crit_valid_q  <= 1'b0;
      crit_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      read_valid_q  <= proc_rd;
      refill_done_q <= last_beat;
      crit_valid_q  <= beat_fire && (beat_q == '0);
      if (proc_rd) read_data_q <= mem[proc_addr];
      if (beat_fire && (beat_q == '0)) crit_data_q <= mem_data;
      if (state_q == StIdle && refill_start) begin
        ref_index_q  <= refill_index;
        ref_way_q    <= refill_way;
        ref_offset_q <= refill_offset;
        beat_q       <= '0;
      end else if (beat_fire) begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  assign mem_ready   = busy;
  assign refill_busy = busy;
  assign refill_done = refill_done_q;
  assign crit_valid  = crit_valid_q;
  assign crit_data   = crit_data_q;
  assign read_data   = read_data_q;
  assign read_valid  = read_valid_q;

endmodule
